// File: rtl/meas_window_ctrl_if.sv
// Result channel from the measurement window controller to the readout side.
// The master presents amplitude/mean with res_valid; the slave accepts with res_ready.
interface meas_window_ctrl_if #(
  parameter int unsigned DW = 12
);
  logic [DW-1:0] res_amp;
  logic [DW-1:0] res_mean;
  logic          res_valid;
  logic          res_ready;

  modport master (
    output res_amp,
    output res_mean,
    output res_valid,
    input  res_ready
  );

  modport slave (
    input  res_amp,
    input  res_mean,
    input  res_valid,
    output res_ready
  );
endinterface

// File: rtl/meas_window_ctrl.sv
// Paces decimated ADC samples into the amplitude/mean datapath, clears it per window,
// and latches the datapath results onto a valid/ready channel.
module meas_window_ctrl #(
  parameter int unsigned DW = 12,
  parameter int unsigned CW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 continuous,
  input  logic [CW-1:0]        decim,
  input  logic [CW-1:0]        win_len,
  input  logic [DW-1:0]        adc_data,
  input  logic [DW-1:0]        amp_in,
  input  logic [DW-1:0]        mean_in,
  output logic [DW-1:0]        meas_data,
  output logic                 sample_en,
  output logic                 meas_clr,
  output logic                 busy,
  output logic                 overrun,
  meas_window_ctrl_if.master   res
);

  typedef enum logic [1:0] {StIdle, StClear, StRun, StLatch} state_e;

  state_e        state_q;
  logic [CW-1:0] dcnt_q;
  logic [CW-1:0] decim_s_q;
  logic [CW-1:0] wlen_s_q;
  logic [CW-1:0] scnt_q;
  logic          strobe;

  // All pulses decode from registered state so nothing is combinational from inputs.
  assign strobe    = (state_q == StRun) && (dcnt_q == '0);
  assign sample_en = strobe;
  assign meas_clr  = (state_q == StClear);
  assign busy      = (state_q != StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      dcnt_q        <= '0;
      decim_s_q     <= '0;
      wlen_s_q      <= '0;
      scnt_q        <= '0;
      meas_data     <= '0;
      overrun       <= 1'b0;
      res.res_amp   <= '0;
      res.res_mean  <= '0;
      res.res_valid <= 1'b0;
    end else begin
      meas_data <= adc_data;

      // A latch below overrides this clear when both happen on the same edge.
      if (res.res_valid && res.res_ready) begin
        res.res_valid <= 1'b0;
      end

      if (stop) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              state_q <= StClear;
              overrun <= 1'b0;
            end
          end
          StClear: begin
            dcnt_q    <= decim;
            decim_s_q <= decim;
            wlen_s_q  <= (win_len == '0) ? CW'(1) : win_len;
            scnt_q    <= '0;
            state_q   <= StRun;
          end
          StRun: begin
            if (strobe) begin
              dcnt_q <= decim_s_q;
              scnt_q <= scnt_q + CW'(1);
              if (scnt_q == wlen_s_q - CW'(1)) begin
                state_q <= StLatch;
              end
            end else begin
              dcnt_q <= dcnt_q - CW'(1);
            end
          end
          StLatch: begin
            res.res_amp   <= amp_in;
            res.res_mean  <= mean_in;
            res.res_valid <= 1'b1;
            if (res.res_valid && !res.res_ready) begin
              overrun <= 1'b1;
            end
            state_q <= continuous ? StClear : StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_meas_window_ctrl.sv
// Directed bench for meas_window_ctrl: single shot, decimation, continuous, overrun,
// abort, start/stop conflict, zero window length and asynchronous reset.
module tb_meas_window_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic        continuous;
  logic [15:0] decim;
  logic [15:0] win_len;
  logic [11:0] adc_data;
  logic [11:0] amp_in;
  logic [11:0] mean_in;
  logic [11:0] meas_data;
  logic        sample_en;
  logic        meas_clr;
  logic        busy;
  logic        overrun;

  int total = 0;
  int bad   = 0;

  meas_window_ctrl_if #(.DW(12)) res_if ();

  meas_window_ctrl #(.DW(12), .CW(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .decim      (decim),
    .win_len    (win_len),
    .adc_data   (adc_data),
    .amp_in     (amp_in),
    .mean_in    (mean_in),
    .meas_data  (meas_data),
    .sample_en  (sample_en),
    .meas_clr   (meas_clr),
    .busy       (busy),
    .overrun    (overrun),
    .res        (res_if)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Consume the next rising edge; afterwards we are 1 time unit into the next cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    decim = '0; win_len = '0; adc_data = '0; amp_in = '0; mean_in = '0;
    res_if.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_meas_data", meas_data, 0);
    chk("rst_sample_en", sample_en, 0);
    chk("rst_meas_clr", meas_clr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_if.res_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_res_amp", res_if.res_amp, 0);
    chk("rst_res_mean", res_if.res_mean, 0);
    rst = 1'b0;
    tick();

    // Single shot, decim=0, win_len=4.
    decim = 16'd0; win_len = 16'd4; amp_in = 12'h0AA; mean_in = 12'h0BB;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      chk("ss_meas_clr", meas_clr, (c == 1));
      chk("ss_sample_en", sample_en, (c >= 2 && c <= 5));
      chk("ss_busy", busy, (c <= 6));
      chk("ss_res_valid", res_if.res_valid, (c == 7));
      if (c >= 2) chk("ss_meas_data", meas_data, 12'((c - 1) * 7 + 1));
      if (c == 7) begin
        chk("ss_res_amp", res_if.res_amp, 12'h123);
        chk("ss_res_mean", res_if.res_mean, 12'h456);
      end
      adc_data = 12'(c * 7 + 1);
      if (c == 6) begin
        amp_in  = 12'h123;
        mean_in = 12'h456;
      end
      if (c < 7) tick();
    end

    // Handshake: accepting the result drops res_valid.
    res_if.res_ready = 1'b1;
    tick();
    chk("hs_res_valid", res_if.res_valid, 0);
    res_if.res_ready = 1'b0;

    // Decimation, decim=2, win_len=4; decim change mid-window ignored.
    decim = 16'd2; win_len = 16'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      if (c == 5) decim = 16'd0;
      chk("dec_meas_clr", meas_clr, (c == 1));
      chk("dec_sample_en", sample_en, (c == 4 || c == 7 || c == 10 || c == 13));
      chk("dec_busy", busy, (c <= 14));
      chk("dec_res_valid", res_if.res_valid, (c == 15));
      if (c < 15) tick();
    end
    chk("dec_overrun", overrun, 0);

    // Continuous, decim=0, win_len=3, res_ready held high.
    win_len = 16'd3; continuous = 1'b1; res_if.res_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      chk("cont_meas_clr", meas_clr, (c % 5 == 1));
      chk("cont_sample_en", sample_en, (c % 5 >= 2 && c % 5 <= 4));
      chk("cont_res_valid", res_if.res_valid, (c > 1 && c % 5 == 1));
      chk("cont_overrun", overrun, 0);
      if (c > 1 && c % 5 == 1) chk("cont_res_amp", res_if.res_amp, 12'(12'h100 + c - 1));
      amp_in = 12'(12'h100 + c);
      if (c == 16) begin
        stop = 1'b1;
        continuous = 1'b0;
      end
      tick();
    end
    chk("cont_stop_busy", busy, 0);
    stop = 1'b0;

    // Overrun: continuous, win_len=1, consumer stalled.
    res_if.res_ready = 1'b0;
    decim = 16'd0; win_len = 16'd1; continuous = 1'b1; amp_in = 12'h011;
    start = 1'b1;
    tick();                                    // cycle 1
    start = 1'b0;
    chk("ov_meas_clr", meas_clr, 1);
    tick();                                    // cycle 2
    chk("ov_sample_en", sample_en, 1);
    tick();                                    // cycle 3, LATCH
    chk("ov_latch_busy", busy, 1);
    chk("ov_latch_se", sample_en, 0);
    tick();                                    // cycle 4
    chk("ov_rv1", res_if.res_valid, 1);
    chk("ov_ov1", overrun, 0);
    chk("ov_amp1", res_if.res_amp, 12'h011);
    amp_in = 12'h022;
    repeat (3) tick();                         // cycle 7
    chk("ov_ov2", overrun, 1);
    chk("ov_rv2", res_if.res_valid, 1);
    chk("ov_amp2", res_if.res_amp, 12'h022);
    chk("ov_reclear", meas_clr, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("ov_stop_busy", busy, 0);
    chk("ov_sticky", overrun, 1);

    // Accepted start clears overrun; win_len=0 behaves as a one-sample window.
    continuous = 1'b0; win_len = 16'd0; res_if.res_ready = 1'b1;
    start = 1'b1;
    tick();                                    // cycle 1
    start = 1'b0;
    chk("wl0_overrun", overrun, 0);
    chk("wl0_rv_acc", res_if.res_valid, 0);
    tick();                                    // cycle 2
    chk("wl0_se", sample_en, 1);
    tick();                                    // cycle 3, LATCH
    chk("wl0_latch_se", sample_en, 0);
    chk("wl0_latch_busy", busy, 1);
    tick();                                    // cycle 4
    chk("wl0_done_busy", busy, 0);
    chk("wl0_rv", res_if.res_valid, 1);
    res_if.res_ready = 1'b0;

    // Abort in cycle 3 of a decim=0, win_len=4 run.
    win_len = 16'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();                                    // cycle 2
    chk("ab_se2", sample_en, 1);
    tick();                                    // cycle 3
    chk("ab_se3", sample_en, 1);
    stop = 1'b1;
    tick();                                    // cycle 4
    stop = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_rv", res_if.res_valid, 1);
    for (int i = 0; i < 3; i++) begin
      chk("ab_no_se", sample_en, 0);
      tick();
    end
    chk("ab_rv_hold", res_if.res_valid, 1);

    // Start and stop held together: stop wins.
    start = 1'b1; stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ss_conflict_busy", busy, 0);
      chk("ss_conflict_clr", meas_clr, 0);
    end
    start = 1'b0; stop = 1'b0;

    // Asynchronous reset in the middle of RUN.
    adc_data = 12'hABC;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();                                    // cycle 2
    chk("ar_pre_se", sample_en, 1);
    chk("ar_pre_data", meas_data, 12'hABC);
    #2 rst = 1'b1;
    #1;
    chk("ar_meas_data", meas_data, 0);
    chk("ar_sample_en", sample_en, 0);
    chk("ar_meas_clr", meas_clr, 0);
    chk("ar_busy", busy, 0);
    chk("ar_res_valid", res_if.res_valid, 0);
    chk("ar_overrun", overrun, 0);
    chk("ar_res_amp", res_if.res_amp, 0);
    chk("ar_res_mean", res_if.res_mean, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("ar_post_busy", busy, 0);
    chk("ar_post_se", sample_en, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
